// File: rtl/slave_access_pkg.sv
// Shared types, widths and the address decoder for the slave access controller.
package slave_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int SLV_IDX_MSB = 7;
  localparam int SLV_IDX_LSB = 5;
  localparam int SLV_IDX_W   = SLV_IDX_MSB - SLV_IDX_LSB + 1;
  // Largest slave count the address field can reach.
  localparam int MAX_SLAVES  = 1 << SLV_IDX_W;

  typedef struct packed {
    logic                  err;
    logic [MAX_SLAVES-1:0] sel;
  } decode_t;

  // Upper address bits pick the slave; an index past the populated slaves is an error.
  function automatic decode_t decode_addr(input logic [ADDR_W-1:0] addr, input int num_slaves);
    decode_t              d;
    logic [SLV_IDX_W-1:0] idx;
    idx   = addr[SLV_IDX_MSB:SLV_IDX_LSB];
    d.err = 1'b0;
    d.sel = '0;
    if (int'(idx) < num_slaves) begin
      d.sel[idx] = 1'b1;
    end else begin
      d.err = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  int               w_pos;
  logic [IDX_W-1:0] w_sel;

  // Scan requesters starting at the pointer, wrapping modulo N; keep the first hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    w_sel   = '0;
    for (int off = 0; off < N; off++) begin
      w_pos = int'(i_ptr) + off;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      w_sel = IDX_W'(w_pos);
      if (!o_valid && i_req[w_sel]) begin
        o_valid        = 1'b1;
        o_grant[w_sel] = 1'b1;
        o_idx          = w_sel;
      end
    end
  end

endmodule

// File: rtl/slave_access_ctrl.sv
// Multi-master access controller: round-robin grant, address decode to a one-hot
// slave select, transfer held until the selected slave acks, one-cycle completion.
// Optional macro SLV_ACC_TIMEOUT_EN adds an ack wait limit of TIMEOUT_CYCLES.
module slave_access_ctrl
  import slave_access_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int NUM_SLAVES     = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_wr_rd,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic                          m_err,
  output logic [DATA_W-1:0]             m_rd_data,
  output logic [NUM_SLAVES-1:0]         sel_en_out,
  output logic                          wr_rd_s_out,
  output logic [ADDR_W-1:0]             addr_out,
  output logic [DATA_W-1:0]             wr_data_out,
  input  logic [DATA_W-1:0]             rd_data_in,
  input  logic [NUM_SLAVES-1:0]         ack_in
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_ptr;
  logic                   r_wr_rd;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wr_data;
  logic [NUM_SLAVES-1:0]  r_sel;
  logic                   r_err;
  logic [DATA_W-1:0]      r_rd_data;

  logic [NUM_MASTERS-1:0] w_gnt_onehot;
  logic [IDX_W-1:0]       w_gnt_idx;
  logic                   w_gnt_valid;
  logic [ADDR_W-1:0]      w_addr_arr    [NUM_MASTERS];
  logic [DATA_W-1:0]      w_wr_data_arr [NUM_MASTERS];
  logic [ADDR_W-1:0]      w_req_addr;
  logic [DATA_W-1:0]      w_req_wr_data;
  logic                   w_req_wr_rd;
  decode_t                w_dec;
  logic                   w_dec_unused;
  logic                   w_ack_hit;
  logic                   w_timeout;

  // Unpack the flat per-master buses into arrays.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign w_addr_arr[gi]    = m_addr[gi*ADDR_W +: ADDR_W];
      assign w_wr_data_arr[gi] = m_wr_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (m_req),
    .i_ptr   (r_ptr),
    .o_grant (w_gnt_onehot),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  // One-hot AND-OR mux of the winning master's transfer fields.
  always_comb begin
    w_req_addr    = '0;
    w_req_wr_data = '0;
    w_req_wr_rd   = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_gnt_onehot[i]) begin
        w_req_addr    = w_req_addr | w_addr_arr[i];
        w_req_wr_data = w_req_wr_data | w_wr_data_arr[i];
        w_req_wr_rd   = w_req_wr_rd | m_wr_rd[i];
      end
    end
  end

  assign w_dec        = decode_addr(w_req_addr, NUM_SLAVES);
  // Select bits above the populated slaves are always zero (those indices flag err).
  assign w_dec_unused = ^w_dec.sel;
  // Only the selected slave's ack counts; the others are ignored.
  assign w_ack_hit    = |(ack_in & r_sel);

`ifdef SLV_ACC_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  // Wait counter: zero outside ACCESS, counts ACCESS cycles without ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != ACCESS) begin
      r_wait_cnt <= '0;
    end else if (!w_ack_hit) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_state == ACCESS) && !w_ack_hit &&
                     (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  // No wait limit in this build: ACCESS holds until the selected slave acks.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: grant in IDLE, wait for ack in ACCESS, single RESP cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_next = w_dec.err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (w_ack_hit || w_timeout) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Transfer registers: capture on grant, capture read data on ack, advance pointer on completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_ptr     <= '0;
      r_wr_rd   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_sel     <= '0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_idx     <= w_gnt_idx;
            r_wr_rd   <= w_req_wr_rd;
            r_addr    <= w_req_addr;
            r_wr_data <= w_req_wr_data;
            r_sel     <= w_dec.sel[NUM_SLAVES-1:0];
            r_err     <= w_dec.err;
            r_rd_data <= '0;
          end
        end
        ACCESS: begin
          if (w_ack_hit) begin
            r_rd_data <= r_wr_rd ? '0 : rd_data_in;
            r_err     <= 1'b0;
          end else if (w_timeout) begin
            r_rd_data <= '0;
            r_err     <= 1'b1;
          end
        end
        RESP: begin
          r_ptr <= (r_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: slave bus only in ACCESS, completion only in RESP, zero otherwise.
  always_comb begin
    m_done      = '0;
    m_err       = 1'b0;
    m_rd_data   = '0;
    sel_en_out  = '0;
    wr_rd_s_out = 1'b0;
    addr_out    = '0;
    wr_data_out = '0;
    case (r_state)
      ACCESS: begin
        sel_en_out  = r_sel;
        wr_rd_s_out = r_wr_rd;
        addr_out    = r_addr;
        wr_data_out = r_wr_data;
      end
      RESP: begin
        m_done[r_idx] = 1'b1;
        m_err         = r_err;
        m_rd_data     = r_rd_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slave_access_ctrl.sv
// Self-checking bench for slave_access_ctrl: directed scenarios plus randomized
// transfers checked against a behavioural arbitration/decode model.
module tb_slave_access_ctrl;

  localparam int NM  = 4;
  localparam int NS  = 5;
  localparam int TMO = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NM-1:0]     m_req;
  logic [NM-1:0]     m_wr_rd;
  logic [NM*8-1:0]   m_addr;
  logic [NM*8-1:0]   m_wr_data;
  logic [NM-1:0]     m_done;
  logic              m_err;
  logic [7:0]        m_rd_data;
  logic [NS-1:0]     sel_en_out;
  logic              wr_rd_s_out;
  logic [7:0]        addr_out;
  logic [7:0]        wr_data_out;
  logic [7:0]        rd_data_in;
  logic [NS-1:0]     ack_in;

  int vectors     = 0;
  int miscompares = 0;
  int model_ptr   = 0;

  always #5 clock = ~clock;

  slave_access_ctrl #(
    .NUM_MASTERS    (NM),
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .m_req       (m_req),
    .m_wr_rd     (m_wr_rd),
    .m_addr      (m_addr),
    .m_wr_data   (m_wr_data),
    .m_done      (m_done),
    .m_err       (m_err),
    .m_rd_data   (m_rd_data),
    .sel_en_out  (sel_en_out),
    .wr_rd_s_out (wr_rd_s_out),
    .addr_out    (addr_out),
    .wr_data_out (wr_data_out),
    .rd_data_in  (rd_data_in),
    .ack_in      (ack_in)
  );

  // Reference model: first requester at or after the pointer, wrapping.
  function automatic int pick_winner(input logic [NM-1:0] req, input int ptr);
    int p;
    for (int k = 0; k < NM; k++) begin
      p = (ptr + k) % NM;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  // Reference model: slave number is the address divided by 32.
  function automatic logic [NS-1:0] expect_sel(input logic [7:0] a);
    int            s;
    logic [NS-1:0] r;
    s = int'(a) / 32;
    r = '0;
    if (s < NS) r[s] = 1'b1;
    return r;
  endfunction

  function automatic logic [NM-1:0] onehot_m(input int i);
    logic [NM-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic test_reset();
    reset_n    = 1'b0;
    m_req      = '0;
    m_wr_rd    = '0;
    m_addr     = '0;
    m_wr_data  = '0;
    rd_data_in = '0;
    ack_in     = '0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({m_done, m_err, m_rd_data, sel_en_out, wr_rd_s_out, addr_out, wr_data_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, want 0",
               {m_done, m_err, m_rd_data, sel_en_out, wr_rd_s_out, addr_out, wr_data_out});
    end
    m_req  = 4'b0001;
    m_addr[7:0] = 8'h20;
    @(negedge clock);
    vectors++;
    if (sel_en_out !== '0 || m_done !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: sel=%b done=%b, want 0/0", sel_en_out, m_done);
    end
    m_req   = '0;
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (sel_en_out !== '0 || m_done !== '0 || m_err !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_req: sel=%b done=%b err=%b, want 0", sel_en_out, m_done, m_err);
    end
    model_ptr = 0;
    $display("reset: done");
  endtask

  task automatic test_single_read();
    m_req       = 4'b0001;
    m_wr_rd[0]  = 1'b0;
    m_addr[7:0] = 8'h41;
    rd_data_in  = 8'hA5;
    ack_in      = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      vectors++;
      if (sel_en_out !== 5'b00100 || wr_rd_s_out !== 1'b0 || addr_out !== 8'h41 || m_done !== '0) begin
        miscompares++;
        $display("FAIL read_access c%0d: sel=%b wr=%b addr=%h done=%b, want 00100/0/41/0000",
                 c, sel_en_out, wr_rd_s_out, addr_out, m_done);
      end
    end
    ack_in = 5'b00100;
    @(negedge clock);
    vectors++;
    if (m_done !== 4'b0001 || m_rd_data !== 8'hA5 || m_err !== 1'b0 || sel_en_out !== '0) begin
      miscompares++;
      $display("FAIL read_done: done=%b rd=%h err=%b sel=%b, want 0001/a5/0/0",
               m_done, m_rd_data, m_err, sel_en_out);
    end
    m_req  = '0;
    ack_in = '0;
    @(negedge clock);
    vectors++;
    if (m_done !== '0 || m_rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL read_pulse_len: done=%b rd=%h, want 0/00", m_done, m_rd_data);
    end
    model_ptr = 1;
    $display("single_read: master 0 slave 2 rd=a5");
  endtask

  task automatic test_write();
    m_req           = 4'b0010;
    m_wr_rd[1]      = 1'b1;
    m_addr[15:8]    = 8'h85;
    m_wr_data[15:8] = 8'h3C;
    rd_data_in      = 8'hFF;
    ack_in          = 5'b10000;
    @(negedge clock);
    vectors++;
    if (sel_en_out !== 5'b10000 || addr_out !== 8'h85 || wr_data_out !== 8'h3C ||
        wr_rd_s_out !== 1'b1 || m_done !== '0) begin
      miscompares++;
      $display("FAIL write_access: sel=%b addr=%h wd=%h wr=%b done=%b, want 10000/85/3c/1/0",
               sel_en_out, addr_out, wr_data_out, wr_rd_s_out, m_done);
    end
    @(negedge clock);
    vectors++;
    if (m_done !== 4'b0010 || m_rd_data !== 8'h00 || m_err !== 1'b0) begin
      miscompares++;
      $display("FAIL write_done_lat2: done=%b rd=%h err=%b, want 0010/00/0", m_done, m_rd_data, m_err);
    end
    m_req  = '0;
    ack_in = '0;
    @(negedge clock);
    vectors++;
    if (m_done !== '0) begin
      miscompares++;
      $display("FAIL write_pulse_len: done=%b, want 0000", m_done);
    end
    model_ptr = 2;
    $display("write: master 1 slave 4 wd=3c");
  endtask

  task automatic test_decode_error();
    m_req          = 4'b0100;
    m_wr_rd[2]     = 1'b0;
    m_addr[23:16]  = 8'hE0;
    ack_in         = '1;
    rd_data_in     = 8'h99;
    @(negedge clock);
    vectors++;
    if (m_done !== 4'b0100 || m_err !== 1'b1 || sel_en_out !== '0 || m_rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL decerr_done: done=%b err=%b sel=%b rd=%h, want 0100/1/0/00",
               m_done, m_err, sel_en_out, m_rd_data);
    end
    m_req  = '0;
    ack_in = '0;
    @(negedge clock);
    vectors++;
    if (m_done !== '0 || m_err !== 1'b0 || sel_en_out !== '0) begin
      miscompares++;
      $display("FAIL decerr_after: done=%b err=%b sel=%b, want 0/0/0", m_done, m_err, sel_en_out);
    end
    model_ptr = 3;
    $display("decode_error: master 2 addr e0");
  endtask

  task automatic test_wrong_ack();
    m_req          = 4'b1000;
    m_wr_rd[3]     = 1'b0;
    m_addr[31:24]  = 8'h3F;
    rd_data_in     = 8'h5A;
    ack_in         = '0;
    @(negedge clock);
    vectors++;
    if (sel_en_out !== 5'b00010) begin
      miscompares++;
      $display("FAIL wrongack_sel: sel=%b, want 00010", sel_en_out);
    end
    for (int c = 0; c < 4; c++) begin
      ack_in = c[0] ? 5'b01000 : 5'b11101;
      @(negedge clock);
      vectors++;
      if (m_done !== '0 || sel_en_out !== 5'b00010) begin
        miscompares++;
        $display("FAIL wrongack_hold c%0d: done=%b sel=%b, want 0000/00010", c, m_done, sel_en_out);
      end
    end
    ack_in = 5'b00010;
    @(negedge clock);
    vectors++;
    if (m_done !== 4'b1000 || m_rd_data !== 8'h5A || m_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wrongack_done: done=%b rd=%h err=%b, want 1000/5a/0", m_done, m_rd_data, m_err);
    end
    m_req  = '0;
    ack_in = '0;
    @(negedge clock);
    model_ptr = 0;
    $display("wrong_ack: master 3 slave 1 completes only on ack_in[1]");
  endtask

  task automatic test_round_robin();
    int last;
    int grants;
    int w;
    int exp_gap;
    m_addr     = {8'h81, 8'h61, 8'h21, 8'h01};
    m_wr_rd    = '0;
    rd_data_in = 8'h77;
    ack_in     = '1;
    m_req      = '1;
    grants     = 0;
    last       = 0;
    for (int c = 1; c <= 20 && grants < 5; c++) begin
      @(negedge clock);
      if (m_done !== '0) begin
        w = pick_winner(4'b1111, model_ptr);
        vectors++;
        if (m_done !== onehot_m(w)) begin
          miscompares++;
          $display("FAIL rr_order grant%0d: done=%b, want %b", grants, m_done, onehot_m(w));
        end
        exp_gap = (grants == 0) ? 2 : 3;
        vectors++;
        if (c - last != exp_gap) begin
          miscompares++;
          $display("FAIL rr_spacing grant%0d: gap=%0d, want %0d", grants, c - last, exp_gap);
        end
        $display("round_robin: grant %0d to master %0d", grants, w);
        model_ptr = (w + 1) % NM;
        last      = c;
        grants++;
        if (grants == 5) begin
          m_req  = '0;
          ack_in = '0;
        end
      end
    end
    vectors++;
    if (grants != 5) begin
      miscompares++;
      $display("FAIL rr_grant_count: got %0d, want 5", grants);
      m_req  = '0;
      ack_in = '0;
    end
    @(negedge clock);
    vectors++;
    if (m_done !== '0) begin
      miscompares++;
      $display("FAIL rr_idle: done=%b, want 0000", m_done);
    end
  endtask

  task automatic test_reset_mid();
    // First a plain transfer from master 2 so the pointer moves to 3.
    m_req         = 4'b0100;
    m_wr_rd       = '0;
    m_addr[23:16] = 8'h60;
    ack_in        = 5'b01000;
    rd_data_in    = 8'h11;
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (m_done !== 4'b0100) begin
      miscompares++;
      $display("FAIL rstmid_pre_done: done=%b, want 0100", m_done);
    end
    model_ptr = 3;
    m_req  = '0;
    ack_in = '0;
    @(negedge clock);
    m_req         = 4'b1100;
    m_addr[31:24] = 8'h20;
    @(negedge clock);
    vectors++;
    if (sel_en_out !== 5'b00010) begin
      miscompares++;
      $display("FAIL rstmid_sel: sel=%b, want 00010", sel_en_out);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({m_done, m_err, m_rd_data, sel_en_out, wr_rd_s_out, addr_out, wr_data_out} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: outputs %h, want 0",
               {m_done, m_err, m_rd_data, sel_en_out, wr_rd_s_out, addr_out, wr_data_out});
    end
    @(negedge clock);
    vectors++;
    if (m_done !== '0 || sel_en_out !== '0) begin
      miscompares++;
      $display("FAIL rstmid_no_done: done=%b sel=%b, want 0/0", m_done, sel_en_out);
    end
    reset_n   = 1'b1;
    model_ptr = 0;
    @(negedge clock);
    vectors++;
    if (sel_en_out !== expect_sel(8'h60)) begin
      miscompares++;
      $display("FAIL rstmid_ptr0_grant: sel=%b, want %b", sel_en_out, expect_sel(8'h60));
    end
    ack_in = 5'b01000;
    @(negedge clock);
    vectors++;
    if (m_done !== onehot_m(pick_winner(4'b1100, model_ptr))) begin
      miscompares++;
      $display("FAIL rstmid_done2: done=%b, want 0100", m_done);
    end
    model_ptr = 3;
    m_req  = 4'b1000;
    ack_in = '0;
    @(negedge clock);
    ack_in = 5'b00010;
    @(negedge clock);
    vectors++;
    if (sel_en_out !== 5'b00010) begin
      miscompares++;
      $display("FAIL rstmid_m3_sel: sel=%b, want 00010", sel_en_out);
    end
    @(negedge clock);
    vectors++;
    if (m_done !== 4'b1000) begin
      miscompares++;
      $display("FAIL rstmid_m3_done: done=%b, want 1000", m_done);
    end
    model_ptr = 0;
    m_req  = '0;
    ack_in = '0;
    @(negedge clock);
    $display("reset_mid: aborted master 3, then masters 2 and 3 served");
  endtask

  task automatic test_random();
    logic [NM-1:0] req;
    logic [NS-1:0] es;
    logic [7:0]    a;
    logic [7:0]    wd;
    logic [7:0]    rd;
    logic [7:0]    exp_rd;
    logic          wr;
    int            w;
    int            delay;
    bit            drop;
    for (int t = 0; t < 40; t++) begin
      req = NM'($urandom_range(1, (1 << NM) - 1));
      for (int i = 0; i < NM; i++) begin
        m_addr[8*i +: 8]    = {3'($urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : $urandom_range(0, 4)),
                               5'($urandom)};
        m_wr_data[8*i +: 8] = 8'($urandom);
        m_wr_rd[i]          = 1'($urandom);
      end
      rd         = 8'($urandom);
      rd_data_in = rd;
      ack_in     = '0;
      m_req      = req;
      w      = pick_winner(req, model_ptr);
      a      = m_addr[8*w +: 8];
      wd     = m_wr_data[8*w +: 8];
      wr     = m_wr_rd[w];
      es     = expect_sel(a);
      delay  = $urandom_range(0, 3);
      drop   = ($urandom_range(0, 3) == 0);
      exp_rd = wr ? 8'h00 : rd;
      if (es == '0) begin
        @(negedge clock);
        vectors++;
        if (m_done !== onehot_m(w) || m_err !== 1'b1 || m_rd_data !== 8'h00 || sel_en_out !== '0) begin
          miscompares++;
          $display("FAIL rand%0d_decerr: done=%b err=%b rd=%h sel=%b, want %b/1/00/0",
                   t, m_done, m_err, m_rd_data, sel_en_out, onehot_m(w));
        end
      end else begin
        for (int c = 0; c <= delay; c++) begin
          @(negedge clock);
          vectors++;
          if (sel_en_out !== es || addr_out !== a || wr_rd_s_out !== wr ||
              wr_data_out !== wd || m_done !== '0) begin
            miscompares++;
            $display("FAIL rand%0d_access c%0d: sel=%b addr=%h wr=%b wd=%h done=%b, want %b/%h/%b/%h/0",
                     t, c, sel_en_out, addr_out, wr_rd_s_out, wr_data_out, m_done, es, a, wr, wd);
          end
          if (drop) m_req[w] = 1'b0;
          ack_in = NS'($urandom) & ~es;
          if (c == delay) ack_in = ack_in | es;
        end
        @(negedge clock);
        vectors++;
        if (m_done !== onehot_m(w) || m_err !== 1'b0 || m_rd_data !== exp_rd || sel_en_out !== '0) begin
          miscompares++;
          $display("FAIL rand%0d_done: done=%b err=%b rd=%h sel=%b, want %b/0/%h/0",
                   t, m_done, m_err, m_rd_data, sel_en_out, onehot_m(w), exp_rd);
        end
      end
      $display("random %0d: req=%b ptr=%0d winner=%0d addr=%h wr=%b", t, req, model_ptr, w, a, wr);
      model_ptr = (w + 1) % NM;
      m_req  = '0;
      ack_in = '0;
      @(negedge clock);
      vectors++;
      if (m_done !== '0 || m_err !== 1'b0 || m_rd_data !== 8'h00) begin
        miscompares++;
        $display("FAIL rand%0d_pulse: done=%b err=%b rd=%h, want 0/0/00", t, m_done, m_err, m_rd_data);
      end
    end
  endtask

`ifdef SLV_ACC_TIMEOUT_EN
  task automatic test_timeout();
    int access_cycles;
    bit finished;
    int w;
    w      = model_ptr;
    m_req  = onehot_m(w);
    m_addr[8*w +: 8] = 8'h00;
    m_wr_rd[w] = 1'b0;
    rd_data_in = 8'hCC;
    ack_in     = '0;
    access_cycles = 0;
    finished      = 1'b0;
    for (int c = 0; c < 3 * TMO && !finished; c++) begin
      @(negedge clock);
      if (sel_en_out === 5'b00001) access_cycles++;
      if (m_done !== '0) begin
        finished = 1'b1;
        vectors++;
        if (m_done !== onehot_m(w) || m_err !== 1'b1 || m_rd_data !== 8'h00 || access_cycles != TMO) begin
          miscompares++;
          $display("FAIL timeout_done: done=%b err=%b rd=%h access=%0d, want %b/1/00/%0d",
                   m_done, m_err, m_rd_data, access_cycles, onehot_m(w), TMO);
        end
      end
    end
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL timeout_expired: no m_done within %0d cycles, want done", 3 * TMO);
    end
    model_ptr = (w + 1) % NM;
    m_req = '0;
    @(negedge clock);
    $display("timeout: master %0d errored after %0d access cycles", w, access_cycles);
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_decode_error();
    test_wrong_ack();
    test_round_robin();
    test_reset_mid();
    test_random();
`ifdef SLV_ACC_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slave_access_ctrl.md
Name: slave_access_ctrl

Overview:
- Multi-master access controller in front of the 5-slave decoder output bus (sel_en_out / wr_rd_s_out / addr_out / wr_data_out / rd_data_in / ack_in).
- Round-robin arbitration among NUM_MASTERS requesters, address decode to a one-hot slave select, transfer held until slave ack, then one-cycle completion back to the granted master.
- Sits between the master-side request ports and the slave-side bus.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- NUM_SLAVES, 5, number of slaves; width of sel_en_out and ack_in.
- TIMEOUT_CYCLES, 16, ack wait limit in cycles; used only with the optional feature.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- m_req  in  NUM_MASTERS  per-master request; held high until own m_done.
- m_wr_rd  in  NUM_MASTERS  per-master direction: 1=write, 0=read.
- m_addr  in  NUM_MASTERS*8  per-master address, master i at bits [8i+7:8i].
- m_wr_data  in  NUM_MASTERS*8  per-master write data, same packing.
- m_done  out  NUM_MASTERS  one-cycle completion pulse to the granted master.
- m_err  out  1  qualifies m_done: decode error or timeout.
- m_rd_data  out  8  read data, valid with m_done.
- sel_en_out  out  NUM_SLAVES  one-hot slave select.
- wr_rd_s_out  out  1  direction to slave.
- addr_out  out  8  address to slave.
- wr_data_out  out  8  write data to slave.
- rd_data_in  in  8  slave read data.
- ack_in  in  NUM_SLAVES  per-slave acknowledge.

Behaviour:
- Reset (async, immediate, also mid-transfer): all outputs 0, FSM=IDLE, rr pointer=0, captured data=0. No m_done is issued for an aborted transfer.
- Decode: slave index = addr[7:5]. Index < NUM_SLAVES selects that slave. Index >= NUM_SLAVES is a decode error.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If any m_req is high, choose the winner: first requester at or after rr pointer, wrapping modulo NUM_MASTERS.
  - Register winner index and its wr_rd/addr/wr_data.
  - Decode OK: go to ACCESS. Decode error: go to RESP with err=1.
  - No request: outputs stay 0.
- ACCESS:
  - sel_en_out, wr_rd_s_out, addr_out, wr_data_out are driven from registers and held stable. Active from the cycle after the request is seen.
  - Wait for ack_in[sel] high at a posedge. Then capture rd_data_in (reads only; writes capture 0), set err=0, go to RESP.
  - ack_in bits of non-selected slaves are ignored.
  - All slave-side outputs return to 0 in the RESP cycle.
- RESP:
  - m_done[winner]=1 for exactly one cycle, with m_err and m_rd_data valid.
  - rr pointer becomes (winner+1) mod NUM_MASTERS. Go to IDLE.
- m_err and m_rd_data are 0 whenever m_done is 0.
- Minimum latency is 3 cycles per transfer: req sampled → ACCESS → ack sampled → RESP pulse. With ack in the first ACCESS cycle, m_done rises 2 cycles after the request is sampled.
- m_req dropping while granted is ignored; the transfer completes and m_done still pulses.
- A new request can be granted in the IDLE cycle after RESP, so back-to-back throughput is 1 transfer per 3 cycles minimum.
- Simultaneous requests: only one grant per transfer. With pointer=2 and requests {0,3}, master 3 wins.

Optional Feature:
- Macro: SLV_ACC_TIMEOUT_EN.
- Defined: an 8-bit wait counter clears on ACCESS entry and increments each ACCESS cycle without ack. On reaching TIMEOUT_CYCLES-1 with no ack, go to RESP with m_err=1 and m_rd_data=0. An ack in that same cycle wins: no error.
- Undefined: no counter; ACCESS waits for ack indefinitely.

Decomposition:
- Shared package slave_access_pkg holds:
  - state enum typedef {IDLE, ACCESS, RESP};
  - ADDR_W=8, DATA_W=8;
  - SLV_IDX_MSB=7, SLV_IDX_LSB=5;
  - decode function addr → one-hot select plus error flag.
- One sub-module: rr_arbiter (request vector + pointer → one-hot grant + index), purely combinational. The FSM stays in the top module.

Test Plan:
- Single read: m_req[0]=1, addr=0x41, ack_in[2] after 2 ACCESS cycles, rd_data_in=0xA5 → sel_en_out=5'b00100, wr_rd_s_out=0, m_done[0] one pulse, m_rd_data=0xA5, m_err=0.
- Write: m_req[1], wr_rd=1, addr=0x85, data=0x3C, immediate ack_in[4] → addr_out=0x85, wr_data_out=0x3C, sel_en_out=5'b10000, m_done[1] exactly 2 cycles after request sampled.
- Round robin: all four requests held, every slave acks at once → grants in order 0,1,2,3,0; no master starved.
- Decode error: addr=0xE0 → sel_en_out never asserts, m_done with m_err=1 on the 2nd cycle.
- Wrong ack: selected slave 1, only ack_in[3] pulses → no completion until ack_in[1].
- Reset mid-ACCESS: reset_n low while sel_en_out=5'b00010 → all outputs 0 immediately, no m_done. After release, pointer=0 and the pending m_req[2] is granted. With SLV_ACC_TIMEOUT_EN and no ack: m_err=1 after TIMEOUT_CYCLES ACCESS cycles.
